// File: rtl/pcr_arbiter.sv
// PCR file with a two-requester (core/host) round-robin front end.
// One transaction in flight: IDLE -> ACCESS -> RESP, swap-style writes.
module pcr_arbiter #(
    parameter int NREGS  = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              io_core_req_valid,
    output logic              io_core_req_ready,
    input  logic              io_core_req_rw,
    input  logic [4:0]        io_core_req_addr,
    input  logic [DATA_W-1:0] io_core_req_data,

    input  logic              io_host_req_valid,
    output logic              io_host_req_ready,
    input  logic              io_host_req_rw,
    input  logic [4:0]        io_host_req_addr,
    input  logic [DATA_W-1:0] io_host_req_data,

    output logic              io_resp_valid,
    input  logic              io_resp_ready,
    output logic              io_resp_src,
    output logic [DATA_W-1:0] io_resp_data,
    output logic              io_resp_err,

    output logic [7:0]        io_status_im
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [5:0] NREGS_W = 6'(NREGS);

    state_t              state_q;
    logic                last_host_q;

    logic                src_q;
    logic                rw_q;
    logic [4:0]          addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                resp_valid_q;
    logic                resp_src_q;
    logic                resp_err_q;
    logic [DATA_W-1:0]   resp_data_q;

    logic [7:0]          status_q;
    logic [DATA_W-1:0]   scratch_q [NREGS];

    logic                idle;
    logic                grant_host_d;
    logic                accept_d;
    logic                in_range_d;
    logic [DATA_W-1:0]   rd_val_d;

    logic                sel_rw_d;
    logic [4:0]          sel_addr_d;
    logic [DATA_W-1:0]   sel_data_d;

    assign idle = (state_q == IDLE);

    // Sole valid wins; on a tie (or no request) the source not granted last wins.
    assign grant_host_d =
        (io_host_req_valid & ~io_core_req_valid) |
        ((io_host_req_valid == io_core_req_valid) & ~last_host_q);

    assign io_core_req_ready = idle & ~grant_host_d;
    assign io_host_req_ready = idle &  grant_host_d;

    assign accept_d =
        (io_core_req_valid & io_core_req_ready) |
        (io_host_req_valid & io_host_req_ready);

    assign sel_rw_d   = grant_host_d ? io_host_req_rw   : io_core_req_rw;
    assign sel_addr_d = grant_host_d ? io_host_req_addr : io_core_req_addr;
    assign sel_data_d = grant_host_d ? io_host_req_data : io_core_req_data;

    assign in_range_d = ({1'b0, addr_q} < NREGS_W);

    // Read mux over the PCR file; unimplemented addresses read as zero.
    always_comb begin
        rd_val_d = '0;
        if (addr_q == 5'd0) begin
            rd_val_d = {{(DATA_W-8){1'b0}}, status_q};
        end
        for (int i = 1; i < NREGS; i++) begin
            if (addr_q == 5'(i)) begin
                rd_val_d = scratch_q[i];
            end
        end
    end

    // Arbitration FSM, response registers and PCR storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_host_q  <= 1'b1;
            src_q        <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_src_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            status_q     <= '0;
            for (int i = 0; i < NREGS; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        src_q       <= grant_host_d;
                        rw_q        <= sel_rw_d;
                        addr_q      <= sel_addr_d;
                        wdata_q     <= sel_data_d;
                        last_host_q <= grant_host_d;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    resp_data_q  <= rd_val_d;
                    resp_err_q   <= ~in_range_d;
                    resp_src_q   <= src_q;
                    resp_valid_q <= 1'b1;
                    if (rw_q && in_range_d) begin
                        if (addr_q == 5'd0) begin
                            status_q <= wdata_q[7:0];
                        end
                        for (int i = 1; i < NREGS; i++) begin
                            if (addr_q == 5'(i)) begin
                                scratch_q[i] <= wdata_q;
                            end
                        end
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (io_resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign io_resp_valid = resp_valid_q;
    assign io_resp_src   = resp_src_q;
    assign io_resp_data  = resp_data_q;
    assign io_resp_err   = resp_err_q;
    assign io_status_im  = status_q;

endmodule

// File: tb/tb_pcr_arbiter.sv
// Bench for pcr_arbiter: directed scenarios plus randomized traffic
// checked against a register-file/arbitration model.
module tb_pcr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_core_req_valid, io_core_req_ready, io_core_req_rw;
    logic [4:0]  io_core_req_addr;
    logic [63:0] io_core_req_data;
    logic        io_host_req_valid, io_host_req_ready, io_host_req_rw;
    logic [4:0]  io_host_req_addr;
    logic [63:0] io_host_req_data;
    logic        io_resp_valid, io_resp_ready, io_resp_src, io_resp_err;
    logic [63:0] io_resp_data;
    logic [7:0]  io_status_im;

    pcr_arbiter #(.NREGS(8), .DATA_W(64)) dut (
        .clk               (clk),
        .reset             (reset),
        .io_core_req_valid (io_core_req_valid),
        .io_core_req_ready (io_core_req_ready),
        .io_core_req_rw    (io_core_req_rw),
        .io_core_req_addr  (io_core_req_addr),
        .io_core_req_data  (io_core_req_data),
        .io_host_req_valid (io_host_req_valid),
        .io_host_req_ready (io_host_req_ready),
        .io_host_req_rw    (io_host_req_rw),
        .io_host_req_addr  (io_host_req_addr),
        .io_host_req_data  (io_host_req_data),
        .io_resp_valid     (io_resp_valid),
        .io_resp_ready     (io_resp_ready),
        .io_resp_src       (io_resp_src),
        .io_resp_data      (io_resp_data),
        .io_resp_err       (io_resp_err),
        .io_status_im      (io_status_im)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // reference model: architectural PCR contents and who was granted last
    logic [63:0] m_mem [8];
    bit          m_last_host;

    // pending requests per source (0 = core, 1 = host)
    bit          pv    [2];
    bit          prw   [2];
    logic [4:0]  paddr [2];
    logic [63:0] pdata [2];

    bit          g_win;
    int          g_acc;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic apply();
        io_core_req_valid = pv[0];
        io_core_req_rw    = prw[0];
        io_core_req_addr  = paddr[0];
        io_core_req_data  = pdata[0];
        io_host_req_valid = pv[1];
        io_host_req_rw    = prw[1];
        io_host_req_addr  = paddr[1];
        io_host_req_data  = pdata[1];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_last_host = 1'b1;
    endtask

    // Leaves the bench at negedge+1 of a cycle where the DUT sits in IDLE.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pv[0] = 0;
        pv[1] = 0;
        apply();
        io_resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", io_resp_valid, 0);
        chk("rst_data", io_resp_data, 0);
        chk("rst_src", io_resp_src, 0);
        chk("rst_err", io_resp_err, 0);
        chk("rst_status", io_status_im, 0);
        chk("rst_core_rdy", io_core_req_ready, 1);
        chk("rst_host_rdy", io_host_req_ready, 0);
    endtask

    // One full transaction from the current pending requests; entered and
    // left at negedge+1 of an IDLE cycle.
    task automatic run_txn(input int stall);
        bit          win;
        logic [4:0]  a;
        logic [63:0] exp_d;
        bit          exp_e;
        apply();
        #1;
        if (pv[0] && pv[1]) win = !m_last_host;
        else                win = pv[1];
        chk("idle_core_rdy", io_core_req_ready, !win);
        chk("idle_host_rdy", io_host_req_ready, win);
        g_win = win;
        g_acc = cyc;
        m_last_host = win;
        a = paddr[win];
        if (a < 8) begin
            exp_d = m_mem[a];
            exp_e = 0;
            if (prw[win])
                m_mem[a] = (a == 0) ? {56'h0, pdata[win][7:0]} : pdata[win];
        end else begin
            exp_d = '0;
            exp_e = 1;
        end
        pv[win] = 0;
        @(negedge clk);
        apply();
        io_resp_ready = 1'($urandom_range(0, 1));
        #1;
        chk("acc_core_rdy", io_core_req_ready, 0);
        chk("acc_host_rdy", io_host_req_ready, 0);
        chk("acc_valid", io_resp_valid, 0);
        @(negedge clk);
        io_resp_ready = (stall == 0);
        #1;
        chk("resp_valid", io_resp_valid, 1);
        chk("resp_src", io_resp_src, win);
        chk("resp_data", io_resp_data, exp_d);
        chk("resp_err", io_resp_err, exp_e);
        chk("status_im", io_status_im, m_mem[0][7:0]);
        chk("resp_core_rdy", io_core_req_ready, 0);
        chk("resp_host_rdy", io_host_req_ready, 0);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (k == stall - 1) io_resp_ready = 1'b1;
            #1;
            chk("stall_valid", io_resp_valid, 1);
            chk("stall_src", io_resp_src, win);
            chk("stall_data", io_resp_data, exp_d);
            chk("stall_core_rdy", io_core_req_ready, 0);
            chk("stall_host_rdy", io_host_req_ready, 0);
        end
        @(negedge clk);
        io_resp_ready = 1'b0;
        #1;
        chk("back_idle", io_resp_valid, 0);
    endtask

    task automatic set_req(input int s, input bit rw, input logic [4:0] a,
                           input logic [63:0] d);
        pv[s]    = 1;
        prw[s]   = rw;
        paddr[s] = a;
        pdata[s] = d;
    endtask

    initial begin
        int prev;
        reset = 1'b1;
        io_resp_ready = 1'b0;
        pv[0] = 0;
        pv[1] = 0;
        apply();
        model_reset();
        do_reset();

        // status write keeps only the low byte
        set_req(0, 1, 5'd0, 64'hFFFF_FFFF_FFFF_FFA5);
        run_txn(0);
        chk("status_a5", io_status_im, 8'hA5);
        set_req(0, 0, 5'd0, 64'h0);
        run_txn(0);

        // both requesters stream reads of addr 3: strict alternation
        do_reset();
        set_req(0, 0, 5'd3, 64'h0);
        set_req(1, 0, 5'd3, 64'h0);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            run_txn(0);
            chk("rr_order", g_win, (i % 2));
            if (i > 0) chk("rr_spacing", g_acc - prev, 3);
            prev = g_acc;
            set_req(g_win ? 1 : 0, 0, 5'd3, 64'h0);
        end
        pv[0] = 0;
        pv[1] = 0;

        // swap semantics on a scratch entry
        set_req(1, 1, 5'd2, 64'h1234);
        run_txn(0);
        set_req(1, 1, 5'd2, 64'h5678);
        run_txn(0);
        set_req(1, 0, 5'd2, 64'h0);
        run_txn(1);

        // out-of-range address
        set_req(0, 1, 5'd9, 64'hDEAD);
        run_txn(0);
        set_req(0, 0, 5'd9, 64'h0);
        run_txn(0);

        // long response stall with the other requester waiting
        set_req(0, 0, 5'd2, 64'h0);
        set_req(1, 1, 5'd4, 64'hABCD);
        run_txn(5);
        run_txn(0);

        // reset while a write sits in ACCESS
        do_reset();
        set_req(0, 1, 5'd1, 64'h77);
        apply();
        @(negedge clk);
        reset = 1'b1;
        pv[0] = 0;
        apply();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        chk("abort_valid", io_resp_valid, 0);
        chk("abort_idle", io_core_req_ready, 1);
        set_req(0, 0, 5'd1, 64'h0);
        run_txn(0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            for (int s = 0; s < 2; s++) begin
                if (!pv[s] && $urandom_range(0, 1) == 1)
                    set_req(s, 1'($urandom_range(0, 1)),
                            5'($urandom_range(0, 11)),
                            {$urandom, $urandom});
            end
            if (!pv[0] && !pv[1])
                set_req(1'($urandom_range(0, 1)), 0,
                        5'($urandom_range(0, 9)), 64'h0);
            run_txn($urandom_range(0, 3));
        end
        while (pv[0] || pv[1]) run_txn(0);

        // final sweep of every implemented entry
        for (int a = 0; a < 8; a++) begin
            set_req(a % 2, 0, 5'(a), 64'h0);
            run_txn(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got %0d exp %0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
